saler_3_always: RTL and testbench



---
 rtl/saler_3_always.sv | 74 +++++++
 tb/tb_saler_3_always.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/saler_3_always.sv
// saler_3_always: coin-operated vending controller.
// Collects credit in half-yuan units and pulses 'out' for one clock on each
// sale. Overpayment is forfeited because the block has no change port.
//
// Ports:
//   CLK  - system clock; all state changes on the rising edge
//   RST  - asynchronous, active-high reset; clears credit and out at once
//   in   - coin code: 00 none, 01 = 1 unit, 10 = 2 units, 11 invalid (ignored)
//   out  - registered one-cycle "transaction success" pulse to the dispenser
//
// Parameter:
//   PRICE - item price in half-yuan units; legal range 2..15
module saler_3_always #(
  parameter int unsigned PRICE = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] in,
  output logic       out
);

  localparam int unsigned CREDIT_W = 4;
  localparam int unsigned SUM_W    = 5;

  // Credit value doubles as the FSM state: S0 (idle) .. S(PRICE-1).
  logic [CREDIT_W-1:0] credit;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [SUM_W-1:0]    coin_val_c;
  logic [SUM_W-1:0]    sum_c;
  logic                sale_c;

  // Coin decode; the invalid code is worth nothing, exactly like "no coin".
  always_comb begin
    coin_val_c = '0;
    case (in)
      2'b01:   coin_val_c = SUM_W'(1);
      2'b10:   coin_val_c = SUM_W'(2);
      default: coin_val_c = '0;
    endcase
  end

  // Five-bit sum so credit plus the largest coin never wraps.
  assign sum_c  = SUM_W'(credit) + coin_val_c;
  assign sale_c = (sum_c >= SUM_W'(PRICE));

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      credit <= '0;
    end else begin
      credit <= credit_nxt;
    end
  end

  // Next state: hold by default; a sale returns to idle and drops any excess.
  always_comb begin
    credit_nxt = credit;
    if (sale_c) begin
      credit_nxt = '0;
    end else begin
      credit_nxt = CREDIT_W'(sum_c);
    end
  end

  // Registered sale pulse; consecutive sales keep it high back to back.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out <= 1'b0;
    end else begin
      out <= sale_c;
    end
  end

endmodule

// File: tb/tb_saler_3_always.sv
// Bench for saler_3_always: a PRICE=5 instance and a PRICE=2 instance driven
// side by side. Each step pushes the model's expected out/credit onto a
// scoreboard queue; after the clock edge the entry is popped and compared.
module tb_saler_3_always;

  logic       CLK;
  logic       RST;
  logic [1:0] in_a;
  logic [1:0] in_b;
  logic       out_a;
  logic       out_b;

  saler_3_always #(.PRICE(5)) u_dut_a (.CLK(CLK), .RST(RST), .in(in_a), .out(out_a));
  saler_3_always #(.PRICE(2)) u_dut_b (.CLK(CLK), .RST(RST), .in(in_b), .out(out_b));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       out_a;
    logic [3:0] cr_a;
    logic       out_b;
    logic [3:0] cr_b;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] m_cr_a = '0;
  logic [3:0] m_cr_b = '0;
  int         m_sales_a   = 0;
  int         dut_sales_a = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [4:0] coin_val(input logic [1:0] c);
    case (c)
      2'b01:   return 5'd1;
      2'b10:   return 5'd2;
      default: return 5'd0;
    endcase
  endfunction

  // One clock: drive coins at the falling edge, predict, compare after the rise.
  task automatic step(input logic [1:0] ca, input logic [1:0] cb);
    exp_t       e;
    logic [4:0] s;
    @(negedge CLK);
    in_a = ca;
    in_b = cb;
    s = 5'(m_cr_a) + coin_val(ca);
    if (s >= 5'd5) begin e.out_a = 1'b1; m_cr_a = '0; m_sales_a++; end
    else begin e.out_a = 1'b0; m_cr_a = s[3:0]; end
    s = 5'(m_cr_b) + coin_val(cb);
    if (s >= 5'd2) begin e.out_b = 1'b1; m_cr_b = '0; end
    else begin e.out_b = 1'b0; m_cr_b = s[3:0]; end
    e.cr_a = m_cr_a;
    e.cr_b = m_cr_b;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check("out_a", 8'(out_a), 8'(e.out_a));
      check("credit_a", 8'(u_dut_a.credit), 8'(e.cr_a));
      check("out_b", 8'(out_b), 8'(e.out_b));
      check("credit_b", 8'(u_dut_b.credit), 8'(e.cr_b));
      if (out_a) dut_sales_a++;
    end
  endtask

  // Mid-cycle reset: outputs and credit must clear before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    RST = 1'b1;
    #1;
    check({tag, "_out_a"}, 8'(out_a), 8'd0);
    check({tag, "_credit_a"}, 8'(u_dut_a.credit), 8'd0);
    check({tag, "_out_b"}, 8'(out_b), 8'd0);
    m_cr_a = '0;
    m_cr_b = '0;
    in_a = 2'b00;
    in_b = 2'b00;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST  = 1'b1;
    in_a = 2'b00;
    in_b = 2'b00;
    #3;
    check("por_out_a", 8'(out_a), 8'd0);
    check("por_credit_a", 8'(u_dut_a.credit), 8'd0);
    @(negedge CLK);
    RST = 1'b0;

    // Build credit 3, reset mid-cycle, then 10,10,01 sells on the third coin.
    step(2'b10, 2'b00);
    step(2'b01, 2'b00);
    check("cr3_before_rst", 8'(u_dut_a.credit), 8'd3);
    do_reset("rst_mid");
    step(2'b10, 2'b00);
    step(2'b10, 2'b00);
    step(2'b01, 2'b00);
    check("sale_after_rst", 8'(out_a), 8'd1);
    step(2'b00, 2'b00);

    // Five half-yuan coins.
    for (int i = 0; i < 5; i++) step(2'b01, 2'b00);
    check("five_halves_sale", 8'(out_a), 8'd1);
    step(2'b00, 2'b00);

    // Overpay: 0.5+1+0.5 then +1 sells at 3.0; next 0.5 leaves credit 1.
    step(2'b01, 2'b00);
    step(2'b10, 2'b00);
    step(2'b01, 2'b00);
    step(2'b10, 2'b00);
    check("overpay_sale", 8'(out_a), 8'd1);
    step(2'b01, 2'b00);
    check("no_carry_credit", 8'(u_dut_a.credit), 8'd1);

    // Pending pulse must be cleared by reset at once.
    step(2'b10, 2'b00);
    step(2'b10, 2'b00);
    check("pending_pulse", 8'(out_a), 8'd1);
    do_reset("rst_pulse");

    // Idle and invalid codes hold state.
    step(2'b10, 2'b00);
    for (int i = 0; i < 3; i++) step(2'b11, 2'b11);
    for (int i = 0; i < 3; i++) step(2'b00, 2'b00);
    check("idle_hold_credit", 8'(u_dut_a.credit), 8'd2);
    step(2'b10, 2'b00);
    step(2'b01, 2'b00);
    check("idle_final_sale", 8'(out_a), 8'd1);
    step(2'b00, 2'b00);

    // Back-to-back sales on the PRICE=2 instance.
    for (int i = 0; i < 4; i++) begin
      step(2'b00, 2'b10);
      check("b2b_out_b", 8'(out_b), 8'd1);
    end
    step(2'b00, 2'b00);
    check("b2b_end_out_b", 8'(out_b), 8'd0);

    // Random soak.
    do_reset("rst_soak");
    m_sales_a   = 0;
    dut_sales_a = 0;
    for (int i = 0; i < 1000; i++) step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    check("soak_sales", 8'(dut_sales_a), 8'(m_sales_a));
    check("soak_sb_drained", 8'(sb.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
